// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the per-stage stall/flush control pair.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      DRAIN   = 2'd2
   } hz_state_e;

   typedef struct packed {
      logic stall;
      logic flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t CTRL_NONE  = '{stall: 1'b0, flush: 1'b0};
   localparam hz_ctrl_t CTRL_STALL = '{stall: 1'b1, flush: 1'b0};
   localparam hz_ctrl_t CTRL_FLUSH = '{stall: 1'b0, flush: 1'b1};

   // True while an instruction older than ID (EX or MEM) is still in flight.
   function automatic logic olderInFlight(input logic [2:0] pipeValid);
      return |pipeValid[2:1];
   endfunction

endpackage

// File: rtl/hz_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID is about to read. x0 never creates a dependency.
module hz_detect
   import pipeline_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] i_idRs1,
   input  logic [REG_AW-1:0] i_idRs2,
   input  logic              i_rs1Used,
   input  logic              i_rs2Used,
   input  logic              i_exLoad,
   input  logic [REG_AW-1:0] i_exRd,
   output logic              o_loadUse
);

   logic w_rs1Hit;
   logic w_rs2Hit;

   assign w_rs1Hit  = i_rs1Used & (i_idRs1 == i_exRd);
   assign w_rs2Hit  = i_rs2Used & (i_idRs2 == i_exRd);
   assign o_loadUse = i_exLoad & (i_exRd != '0) & (w_rs1Hit | w_rs2Hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline: memory wait,
// redirect, load-use, fence drain and fetch bubbles, plus stall statistics.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic              id_fence_i,
   input  logic              ex_load_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_redirect_i,
   input  logic              imem_ready_i,
   input  logic              mem_req_i,
   input  logic              dmem_ready_i,
   input  logic [2:0]        pipe_valid_i,
   output logic              pc_stall_o,
   output logic              ifid_stall_o,
   output logic              ifid_flush_o,
   output logic              idex_stall_o,
   output logic              idex_flush_o,
   output logic              exmem_stall_o,
   output logic              exmem_flush_o,
   output logic              memwb_stall_o,
   output logic              memwb_flush_o,
   output logic [1:0]        state_o,
   output logic              mem_timeout_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   hz_state_e         r_state;
   hz_state_e         w_stateNext;
   hz_state_e         w_evalState;
   logic [WAIT_W-1:0] r_waitCnt;
   logic [CNT_W-1:0]  r_stallCnt;

   logic     w_memStall;
   logic     w_loadUse;
   logic     w_drain;
   logic     w_olderValid;
   logic     w_timeout;
   logic     w_pcStall;
   logic     w_unusedIdValid;
   hz_ctrl_t w_ifid;
   hz_ctrl_t w_idex;
   hz_ctrl_t w_exmem;
   hz_ctrl_t w_memwb;

   hz_detect #(
      .REG_AW (REG_AW)
   ) u_detect (
      .i_idRs1   (id_rs1_i),
      .i_idRs2   (id_rs2_i),
      .i_rs1Used (id_rs1_used_i),
      .i_rs2Used (id_rs2_used_i),
      .i_exLoad  (ex_load_i),
      .i_exRd    (ex_rd_i),
      .o_loadUse (w_loadUse)
   );

   // The ID valid bit is implied by the fence/operand flags the decoder drives.
   assign w_unusedIdValid = pipe_valid_i[0];

   assign w_memStall   = mem_req_i & ~dmem_ready_i;
   assign w_olderValid = olderInFlight(pipe_valid_i);

   // The cycle in which dmem completes already behaves as RUN.
   always_comb begin
      w_evalState = r_state;
      if (r_state == MEMWAIT && dmem_ready_i) begin
         w_evalState = RUN;
      end
   end

   assign w_drain = w_olderValid &
                    ((w_evalState == DRAIN) | ((w_evalState == RUN) & id_fence_i));

   // Next-state logic; a memory stall freezes DRAIN without leaving it.
   always_comb begin
      w_stateNext = r_state;
      unique case (w_evalState)
         RUN: begin
            if (w_memStall) begin
               w_stateNext = MEMWAIT;
            end else if (w_drain && !ex_redirect_i) begin
               w_stateNext = DRAIN;
            end else begin
               w_stateNext = RUN;
            end
         end
         MEMWAIT: w_stateNext = MEMWAIT;
         DRAIN: begin
            if (!w_memStall && (ex_redirect_i || !w_olderValid)) begin
               w_stateNext = RUN;
            end
         end
         default: w_stateNext = RUN;
      endcase
   end

   // Priority-ordered stage controls; stalls always cover every earlier stage.
   always_comb begin
      w_pcStall = 1'b0;
      w_ifid    = CTRL_NONE;
      w_idex    = CTRL_NONE;
      w_exmem   = CTRL_NONE;
      w_memwb   = CTRL_NONE;
      if (!rst_ni) begin
         w_pcStall = 1'b1;
         w_ifid    = CTRL_FLUSH;
         w_idex    = CTRL_FLUSH;
         w_exmem   = CTRL_FLUSH;
         w_memwb   = CTRL_FLUSH;
      end else if (w_memStall) begin
         w_pcStall = 1'b1;
         w_ifid    = CTRL_STALL;
         w_idex    = CTRL_STALL;
         w_exmem   = CTRL_STALL;
         w_memwb   = CTRL_FLUSH;
      end else if (ex_redirect_i) begin
         w_ifid = CTRL_FLUSH;
         w_idex = CTRL_FLUSH;
      end else if (w_loadUse || w_drain) begin
         w_pcStall = 1'b1;
         w_ifid    = CTRL_STALL;
         w_idex    = CTRL_FLUSH;
      end else if (!imem_ready_i) begin
         w_pcStall = 1'b1;
         w_ifid    = CTRL_FLUSH;
      end
   end

   assign w_timeout = (MEM_TIMEOUT != 0) && (w_evalState == MEMWAIT) &&
                      (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= RUN;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Wait counter saturates at MEM_TIMEOUT so the timeout pulse fires only once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_waitCnt <= '0;
      end else if (w_evalState == MEMWAIT) begin
         if (r_waitCnt != WAIT_W'(MEM_TIMEOUT)) begin
            r_waitCnt <= r_waitCnt + WAIT_W'(1);
         end
      end else begin
         r_waitCnt <= '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stallCnt <= '0;
      end else if (w_pcStall && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
   end

   assign pc_stall_o    = w_pcStall;
   assign ifid_stall_o  = w_ifid.stall;
   assign ifid_flush_o  = w_ifid.flush;
   assign idex_stall_o  = w_idex.stall;
   assign idex_flush_o  = w_idex.flush;
   assign exmem_stall_o = w_exmem.stall;
   assign exmem_flush_o = w_exmem.flush;
   assign memwb_stall_o = w_memwb.stall;
   assign memwb_flush_o = w_memwb.flush;
   assign state_o       = r_state;
   assign mem_timeout_o = w_timeout;
   assign stall_cnt_o   = r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a table of single-cycle RUN vectors
// followed by hand-written multi-cycle sequences, checked through a scoreboard.
module tb_hazard_ctrl;

   localparam logic [8:0] NONE = 9'b0_00_00_00_00;
   localparam logic [8:0] LU   = 9'b1_10_01_00_00;
   localparam logic [8:0] RD   = 9'b0_01_01_00_00;
   localparam logic [8:0] MS   = 9'b1_10_10_10_01;
   localparam logic [8:0] IM   = 9'b1_01_00_00_00;
   localparam logic [8:0] RST  = 9'b1_01_01_01_01;
   localparam logic [1:0] S_RUN = 2'd0;
   localparam logic [1:0] S_MW  = 2'd1;
   localparam logic [1:0] S_DR  = 2'd2;

   typedef struct {
      logic [4:0] rs1;
      logic       rs1Used;
      logic [4:0] rs2;
      logic       rs2Used;
      logic       exLoad;
      logic [4:0] exRd;
      logic       redirect;
      logic       imemReady;
      logic       memReq;
      logic       dmemReady;
      logic       fence;
      logic [2:0] pv;
      logic [8:0] expCtrl;
      logic [1:0] expState;
      logic       expTimeout;
   } vec_t;

   logic        clk;
   logic        rstN;
   logic [4:0]  idRs1, idRs2, exRd;
   logic        rs1Used, rs2Used, fence, exLoad, redirect;
   logic        imemReady, memReq, dmemReady;
   logic [2:0]  pipeValid;
   logic        pcStall, ifidStall, ifidFlush, idexStall, idexFlush;
   logic        exmemStall, exmemFlush, memwbStall, memwbFlush;
   logic [1:0]  state;
   logic        memTimeout;
   logic [31:0] stallCnt;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expCnt;
   vec_t        sbQ[$];
   vec_t        vecs[$];

   hazard_ctrl #(
      .REG_AW      (5),
      .MEM_TIMEOUT (4),
      .CNT_W       (32)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rstN),
      .id_rs1_i      (idRs1),
      .id_rs2_i      (idRs2),
      .id_rs1_used_i (rs1Used),
      .id_rs2_used_i (rs2Used),
      .id_fence_i    (fence),
      .ex_load_i     (exLoad),
      .ex_rd_i       (exRd),
      .ex_redirect_i (redirect),
      .imem_ready_i  (imemReady),
      .mem_req_i     (memReq),
      .dmem_ready_i  (dmemReady),
      .pipe_valid_i  (pipeValid),
      .pc_stall_o    (pcStall),
      .ifid_stall_o  (ifidStall),
      .ifid_flush_o  (ifidFlush),
      .idex_stall_o  (idexStall),
      .idex_flush_o  (idexFlush),
      .exmem_stall_o (exmemStall),
      .exmem_flush_o (exmemFlush),
      .memwb_stall_o (memwbStall),
      .memwb_flush_o (memwbFlush),
      .state_o       (state),
      .mem_timeout_o (memTimeout),
      .stall_cnt_o   (stallCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(
      input logic [4:0] rs1, input logic rs1U, input logic [4:0] rs2, input logic rs2U,
      input logic ld, input logic [4:0] rd, input logic redir, input logic imemR,
      input logic mReq, input logic dmemR, input logic fen, input logic [2:0] pv,
      input logic [8:0] eCtrl, input logic [1:0] eState, input logic eTo);
      vec_t v;
      v.rs1 = rs1; v.rs1Used = rs1U; v.rs2 = rs2; v.rs2Used = rs2U;
      v.exLoad = ld; v.exRd = rd; v.redirect = redir; v.imemReady = imemR;
      v.memReq = mReq; v.dmemReady = dmemR; v.fence = fen; v.pv = pv;
      v.expCtrl = eCtrl; v.expState = eState; v.expTimeout = eTo;
      return v;
   endfunction

   function automatic logic [8:0] actualCtrl();
      return {pcStall, ifidStall, ifidFlush, idexStall, idexFlush,
              exmemStall, exmemFlush, memwbStall, memwbFlush};
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input vec_t v);
      idRs1 = v.rs1; rs1Used = v.rs1Used; idRs2 = v.rs2; rs2Used = v.rs2Used;
      exLoad = v.exLoad; exRd = v.exRd; redirect = v.redirect;
      imemReady = v.imemReady; memReq = v.memReq; dmemReady = v.dmemReady;
      fence = v.fence; pipeValid = v.pv;
   endtask

   task automatic applyStimulus(input vec_t v);
      driveInputs(v);
      sbQ.push_back(v);
   endtask

   task automatic checkOutput(input string tag);
      vec_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: scoreboard empty, got 0, expected 1 entry", tag);
         return;
      end
      e = sbQ.pop_front();
      checkValue({tag, ".ctrl"}, {23'd0, actualCtrl()}, {23'd0, e.expCtrl});
      checkValue({tag, ".state"}, {30'd0, state}, {30'd0, e.expState});
      checkValue({tag, ".timeout"}, {31'd0, memTimeout}, {31'd0, e.expTimeout});
      checkValue({tag, ".stallCnt"}, stallCnt, expCnt);
      if (e.expCtrl[8]) expCnt = expCnt + 32'd1;
   endtask

   task automatic step(input vec_t v, input string tag);
      @(posedge clk);
      #1;
      applyStimulus(v);
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t idle, ms, msReady;
      idle    = mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, NONE, S_RUN, 1'b0);
      ms      = mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, MS, S_MW, 1'b0);
      msReady = mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, NONE, S_MW, 1'b0);
      expCnt  = 32'd0;
      rstN    = 1'b0;
      driveInputs(idle);

      // Power-on reset and release.
      #12;
      checkValue("reset.ctrl", {23'd0, actualCtrl()}, {23'd0, RST});
      checkValue("reset.state", {30'd0, state}, 32'd0);
      checkValue("reset.timeout", {31'd0, memTimeout}, 32'd0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      #1;
      checkValue("release.ctrl", {23'd0, actualCtrl()}, {23'd0, NONE});
      checkValue("release.stallCnt", stallCnt, 32'd0);

      // Single-cycle vectors evaluated in RUN that leave the state in RUN.
      vecs.push_back(mkVec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, LU,   S_RUN, 1'b0));
      vecs.push_back(idle);
      vecs.push_back(mkVec(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, NONE, S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, LU,   S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, NONE, S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, RD,   S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, IM,   S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, LU,   S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, RD,   S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, NONE, S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, NONE, S_RUN, 1'b0));
      vecs.push_back(mkVec(5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, NONE, S_RUN, 1'b0));
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // Memory wait: three stalled cycles, then completion.
      ms.expState = S_RUN; step(ms, "memwait0");
      ms.expState = S_MW;  step(ms, "memwait1");
      step(ms, "memwait2");
      step(msReady, "memwait.done");
      step(idle, "memwait.run");

      // Timeout: dmem never ready, pulse on the 4th MEMWAIT cycle only.
      ms.expState = S_RUN; step(ms, "timeout0");
      ms.expState = S_MW;
      for (int i = 1; i <= 5; i++) begin
         ms.expTimeout = (i == 4);
         step(ms, $sformatf("timeout%0d", i));
      end
      ms.expTimeout = 1'b0;
      step(msReady, "timeout.done");
      step(idle, "timeout.run");

      // Fence drain: ID held while EX/MEM empty out, released on the return to RUN.
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111, LU,   S_RUN, 1'b0), "fence0");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101, LU,   S_DR,  1'b0), "fence1");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, NONE, S_DR,  1'b0), "fence2");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001, NONE, S_RUN, 1'b0), "fence3");

      // Redirect cancels a drain.
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, LU,   S_RUN, 1'b0), "fredir0");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, RD,   S_DR,  1'b0), "fredir1");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, NONE, S_RUN, 1'b0), "fredir2");

      // Memory stall inside DRAIN keeps the state even though EX/MEM are empty.
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, LU,   S_RUN, 1'b0), "fmem0");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, MS,   S_DR,  1'b0), "fmem1");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, NONE, S_DR,  1'b0), "fmem2");
      step(mkVec(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, NONE, S_RUN, 1'b0), "fmem3");

      // Asynchronous reset in the middle of MEMWAIT.
      ms.expState = S_RUN; step(ms, "rstmw0");
      ms.expState = S_MW;  step(ms, "rstmw1");
      @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      checkValue("rstmw.state", {30'd0, state}, 32'd0);
      checkValue("rstmw.ctrl", {23'd0, actualCtrl()}, {23'd0, RST});
      checkValue("rstmw.timeout", {31'd0, memTimeout}, 32'd0);
      checkValue("rstmw.stallCnt", stallCnt, 32'd0);
      expCnt = 32'd0;
      @(posedge clk);
      #1;
      driveInputs(idle);
      rstN = 1'b1;
      #1;
      checkValue("rstmw.release.ctrl", {23'd0, actualCtrl()}, {23'd0, NONE});
      checkValue("rstmw.release.stallCnt", stallCnt, 32'd0);
      step(idle, "rstmw.idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
